// File: rtl/complex_mac_acc.sv
// rtl/complex_mac_acc.sv - pipelined complex multiply-accumulate with round/saturate output
//
// Streams signed fixed-point complex operand pairs, forms each product with the
// 3-multiplier (Gauss) decomposition, accumulates at full precision across a
// vector delimited by in_last and emits one rounded, saturated result per vector.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid, in_last     beat qualifier and end-of-vector marker
//   in_conj               per-beat conjugate of b (negates b_i)
//   a_r, a_i, b_r, b_i    signed Q(WIDTH-FRAC).FRAC operand components
//   clear                 synchronous abort of all in-flight and partial work
//   out_valid             one-cycle result strobe
//   out_r, out_i          rounded, saturated result (held between strobes)
//   out_sat               either component clamped on this result

module complex_mac_acc #(
  parameter int WIDTH       = 16,
  parameter int FRAC        = 14,
  parameter int ACC_WIDTH   = 2*WIDTH+10,
  parameter int MULT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic                    in_conj,
  input  logic signed [WIDTH-1:0] a_r,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_r,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic                    clear,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_r,
  output logic signed [WIDTH-1:0] out_i,
  output logic                    out_sat
);

  localparam int PW = WIDTH + 1;       // pre-adder width
  localparam int KW = 2*WIDTH + 2;     // full product width
  localparam int AW = ACC_WIDTH;
  localparam int ML = MULT_CYCLES - 1; // index of last multiplier register

  // Rounding and clamp constants, one bit wider than the accumulator so the
  // rounding add can never wrap.
  localparam logic signed [AW:0] RND  = {{AW{1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [AW:0] MAXV = {{(AW+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Stage P: conjugate select and pre-adders
  // ---------------------------------------------------------------------------
  logic                    p_valid_d, p_valid_q;
  logic                    p_last_d,  p_last_q;
  logic signed [PW-1:0]    s0_d, s0_q;
  logic signed [PW-1:0]    s1_d, s1_q;
  logic signed [PW-1:0]    s2_d, s2_q;
  logic signed [WIDTH-1:0] ar_d, ar_q;
  logic signed [WIDTH-1:0] ai_d, ai_q;
  logic signed [WIDTH-1:0] br_d, br_q;
  logic signed [PW-1:0]    bi_adj;

  always_comb begin
    // Negation is done at PW bits so -(-2^(WIDTH-1)) is representable.
    bi_adj    = in_conj ? -PW'(b_i) : PW'(b_i);
    s0_d      = PW'(a_r) + PW'(a_i);
    s1_d      = bi_adj - PW'(b_r);
    s2_d      = PW'(b_r) + bi_adj;
    ar_d      = a_r;
    ai_d      = a_i;
    br_d      = b_r;
    // A beat presented together with clear is dropped.
    p_valid_d = in_valid & ~clear;
    p_last_d  = in_valid & in_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      ar_q      <= '0;
      ai_q      <= '0;
      br_q      <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_last_q  <= p_last_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      ar_q      <= ar_d;
      ai_q      <= ai_d;
      br_q      <= br_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage M: three multipliers followed by MULT_CYCLES-1 retiming registers
  // ---------------------------------------------------------------------------
  logic signed [KW-1:0]   k1_d [MULT_CYCLES];
  logic signed [KW-1:0]   k1_q [MULT_CYCLES];
  logic signed [KW-1:0]   k2_d [MULT_CYCLES];
  logic signed [KW-1:0]   k2_q [MULT_CYCLES];
  logic signed [KW-1:0]   k3_d [MULT_CYCLES];
  logic signed [KW-1:0]   k3_q [MULT_CYCLES];
  logic [MULT_CYCLES-1:0] m_valid_d, m_valid_q;
  logic [MULT_CYCLES-1:0] m_last_d,  m_last_q;

  always_comb begin
    // Operands are sign-extended to the product width so the products are exact.
    k1_d[0]      = KW'(br_q) * KW'(s0_q);
    k2_d[0]      = KW'(ar_q) * KW'(s1_q);
    k3_d[0]      = KW'(ai_q) * KW'(s2_q);
    m_valid_d[0] = p_valid_q & ~clear;
    m_last_d[0]  = p_last_q;
    for (int i = 1; i < MULT_CYCLES; i++) begin
      k1_d[i]      = k1_q[i-1];
      k2_d[i]      = k2_q[i-1];
      k3_d[i]      = k3_q[i-1];
      m_valid_d[i] = m_valid_q[i-1] & ~clear;
      m_last_d[i]  = m_last_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= '0;
      m_last_q  <= '0;
      for (int i = 0; i < MULT_CYCLES; i++) begin
        k1_q[i] <= '0;
        k2_q[i] <= '0;
        k3_q[i] <= '0;
      end
    end else begin
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      for (int i = 0; i < MULT_CYCLES; i++) begin
        k1_q[i] <= k1_d[i];
        k2_q[i] <= k2_d[i];
        k3_q[i] <= k3_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage S: post-adders, widened to the accumulator width
  //   pr = k1 - k3 = br*ar - ai*bi,  pi = k1 + k2 = br*ai + ar*bi
  // ---------------------------------------------------------------------------
  logic                 s_valid_d, s_valid_q;
  logic                 s_last_d,  s_last_q;
  logic signed [AW-1:0] pr_d, pr_q;
  logic signed [AW-1:0] pi_d, pi_q;

  always_comb begin
    pr_d      = AW'(k1_q[ML]) - AW'(k3_q[ML]);
    pi_d      = AW'(k1_q[ML]) + AW'(k2_q[ML]);
    s_valid_d = m_valid_q[ML] & ~clear;
    s_last_d  = m_last_q[ML];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
      pr_q      <= '0;
      pi_q      <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_last_q  <= s_last_d;
      pr_q      <= pr_d;
      pi_q      <= pi_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage A: accumulate. first_q marks that the next valid beat starts a new
  // vector, so it overwrites rather than adds; this avoids a separate zeroing
  // cycle between back-to-back vectors.
  // ---------------------------------------------------------------------------
  logic                 first_d, first_q;
  logic                 a_emit_d, a_emit_q;
  logic signed [AW-1:0] acc_r_d, acc_r_q;
  logic signed [AW-1:0] acc_i_d, acc_i_q;

  always_comb begin
    acc_r_d  = acc_r_q;
    acc_i_d  = acc_i_q;
    first_d  = first_q;
    a_emit_d = 1'b0;
    if (clear) begin
      // The beat sitting in S is in flight and is discarded with the rest.
      first_d = 1'b1;
    end else if (s_valid_q) begin
      if (first_q) begin
        acc_r_d = pr_q;
        acc_i_d = pi_q;
      end else begin
        acc_r_d = acc_r_q + pr_q;
        acc_i_d = acc_i_q + pi_q;
      end
      first_d  = s_last_q;
      a_emit_d = s_last_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q  <= 1'b1;
      a_emit_q <= 1'b0;
      acc_r_q  <= '0;
      acc_i_q  <= '0;
    end else begin
      first_q  <= first_d;
      a_emit_q <= a_emit_d;
      acc_r_q  <= acc_r_d;
      acc_i_q  <= acc_i_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage R: round half toward +inf, then clamp to the output range.
  // Returns {saturated, value}.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH:0] round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW:0] t;
    t = ($signed({acc[AW-1], acc}) + RND) >>> FRAC;
    if (t > MAXV) begin
      round_sat = {1'b1, MAXV[WIDTH-1:0]};
    end else if (t < MINV) begin
      round_sat = {1'b1, MINV[WIDTH-1:0]};
    end else begin
      round_sat = {1'b0, t[WIDTH-1:0]};
    end
  endfunction

  logic                    out_valid_d, out_valid_q;
  logic signed [WIDTH-1:0] out_r_d, out_r_q;
  logic signed [WIDTH-1:0] out_i_d, out_i_q;
  logic                    out_sat_d, out_sat_q;
  logic [WIDTH:0]          rs_r, rs_i;

  always_comb begin
    rs_r        = round_sat(acc_r_q);
    rs_i        = round_sat(acc_i_q);
    out_valid_d = a_emit_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_sat_d   = out_sat_q;
    if (a_emit_q) begin
      out_r_d   = rs_r[WIDTH-1:0];
      out_i_d   = rs_i[WIDTH-1:0];
      out_sat_d = rs_r[WIDTH] | rs_i[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_complex_mac_acc.sv
// tb/tb_complex_mac_acc.sv - scoreboard testbench for complex_mac_acc

module tb_complex_mac_acc;

  localparam int W   = 16;
  localparam int FR  = 14;
  localparam int MC  = 2;
  localparam int AW  = 2*W+10;
  localparam int LAT = MC + 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid, in_last, in_conj, clear;
  logic signed [W-1:0] a_r, a_i, b_r, b_i;
  logic                out_valid, out_sat;
  logic signed [W-1:0] out_r, out_i;

  complex_mac_acc #(
    .WIDTH(W), .FRAC(FR), .ACC_WIDTH(AW), .MULT_CYCLES(MC)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_last(in_last), .in_conj(in_conj),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
    .clear(clear),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    longint r;
    longint i;
    bit     sat;
    int     due;
  } exp_t;
  exp_t sb[$];

  longint m_acc_r = 0;
  longint m_acc_i = 0;
  bit     m_first = 1'b1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic longint rnd_sat(input longint acc, output bit sat);
    longint t;
    longint hi, lo;
    hi  = (longint'(1) <<< (W-1)) - 1;
    lo  = -(longint'(1) <<< (W-1));
    t   = (acc + (longint'(1) <<< (FR-1))) >>> FR;
    sat = 1'b0;
    if (t > hi) begin t = hi; sat = 1'b1; end
    else if (t < lo) begin t = lo; sat = 1'b1; end
    return t;
  endfunction

  // Drive one cycle of stimulus and advance the reference model.
  task automatic beat(input bit v, input bit l, input bit cj,
                      input int ar, input int ai, input int br, input int bi,
                      input bit clr);
    longint pr, pi, bii, rr, ri;
    bit     sr, si;
    @(posedge clk); #1;
    in_valid = v;
    in_last  = l;
    in_conj  = cj;
    a_r      = ar[W-1:0];
    a_i      = ai[W-1:0];
    b_r      = br[W-1:0];
    b_i      = bi[W-1:0];
    clear    = clr;
    if (clr) begin
      m_first = 1'b1;
    end else if (v) begin
      bii = cj ? -longint'(bi) : longint'(bi);
      pr  = longint'(ar) * br - longint'(ai) * bii;
      pi  = longint'(ar) * bii + longint'(ai) * br;
      if (m_first) begin
        m_acc_r = pr;
        m_acc_i = pi;
      end else begin
        m_acc_r = m_acc_r + pr;
        m_acc_i = m_acc_i + pi;
      end
      m_first = 1'b0;
      if (l) begin
        rr = rnd_sat(m_acc_r, sr);
        ri = rnd_sat(m_acc_i, si);
        sb.push_back('{rr, ri, sr | si, cyc + LAT});
        m_first = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  function automatic int rv();
    return int'($urandom_range(0, 65534)) - 32767;
  endfunction

  // Output monitor: every strobe must match the oldest expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_r", out_r, e.r);
        chk("out_i", out_i, e.i);
        chk("out_sat", out_sat, e.sat);
        chk("latency", cyc, e.due);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_conj  = 1'b0;
    clear    = 1'b0;
    a_r = '0; a_i = '0; b_r = '0; b_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_r", out_r, 0);
    chk("rst_i", out_i, 0);
    chk("rst_sat", out_sat, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic product, then hold check between strobes.
    beat(1, 1, 0, 8192, 8192, 8192, -8192, 0);
    idle(9);
    chk("hold_r", out_r, 8192);
    chk("hold_i", out_i, 0);

    // Conjugate mode.
    beat(1, 1, 1, 8192, 8192, 8192, -8192, 0);
    idle(9);

    // Accumulate with a bubble inside the vector.
    beat(1, 0, 0, 16384, 0, 4096, 0, 0);
    beat(1, 0, 0, 16384, 0, 4096, 0, 0);
    idle(1);
    beat(1, 0, 0, 16384, 0, 4096, 0, 0);
    beat(1, 1, 0, 16384, 0, 4096, 0, 0);
    idle(9);

    // Positive and negative saturation.
    repeat (3) beat(1, 0, 0, 24576, 0, 24576, 0, 0);
    beat(1, 1, 0, 24576, 0, 24576, 0, 0);
    idle(9);
    repeat (3) beat(1, 0, 0, 24576, 0, -24576, 0, 0);
    beat(1, 1, 0, 24576, 0, -24576, 0, 0);
    idle(9);

    // Rounding, as consecutive single-beat vectors.
    beat(1, 1, 0, 1, 0, 8192, 0, 0);
    beat(1, 1, 0, -1, 0, 8192, 0, 0);
    idle(9);

    // clear discards a partial vector.
    repeat (3) beat(1, 0, 0, 12000, -3000, 7000, 5000, 0);
    beat(0, 0, 0, 0, 0, 0, 0, 1);
    beat(1, 1, 0, 8192, 8192, 8192, -8192, 0);
    idle(9);

    // A valid last beat presented with clear is dropped.
    repeat (2) beat(1, 0, 0, 9000, 9000, 9000, 9000, 0);
    beat(1, 1, 0, 9000, 9000, 9000, 9000, 1);
    beat(1, 1, 0, 8192, 8192, 8192, -8192, 0);
    idle(9);

    // Random back-to-back singles.
    for (int k = 0; k < 10; k++)
      beat(1, 1, 1'($urandom_range(0, 1)), rv(), rv(), rv(), rv(), 0);
    idle(9);

    // Random vectors with bubbles and mixed conjugation.
    for (int v = 0; v < 20; v++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        beat(1, k == len - 1, 1'($urandom_range(0, 1)), rv(), rv(), rv(), rv(), 0);
      end
    end
    idle(9);

    // Async reset mid-vector.
    beat(1, 1, 0, 8192, 8192, 8192, -8192, 0);
    idle(9);
    beat(1, 0, 0, 20000, 100, 20000, 100, 0);
    beat(1, 0, 0, 20000, 100, 20000, 100, 0);
    @(posedge clk); #3;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_r", out_r, 0);
    chk("arst_i", out_i, 0);
    chk("arst_sat", out_sat, 0);
    m_first = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(10);
    beat(1, 1, 0, 8192, 8192, 8192, -8192, 0);
    idle(9);

    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/complex_mac_acc.md
# complex_mac_acc

Parametrised, fully pipelined complex multiply-accumulate engine. It is the successor to the fixed 11/16-bit canonical complex mult-add. It streams pairs of signed fixed-point complex operands and forms each product with the 3-multiplier (Gauss) decomposition. Products are accumulated at full precision across a vector delimited by `in_last`. At the end of each vector it emits one rounded, saturated complex result. It sits in the CNN datapath behind the FFT stage, where it computes frequency-domain dot products for convolution.

## Interface
- `WIDTH`, 16: operand and result width per component, signed two's complement.
- `FRAC`, 14: fractional bits of operands and result (Q(WIDTH-FRAC).FRAC).
- `ACC_WIDTH`, 2*WIDTH+10: accumulator width per component; must be at least 2*WIDTH+2.
- `MULT_CYCLES`, 2: multiplier pipeline depth; must be at least 1.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: beat qualifier.
- `in_last`  in  1: final beat of the current vector; ignored when `in_valid`=0.
- `in_conj`  in  1: per-beat mode; when 1, use conj(b), i.e. negate `b_i`.
- `a_r`, `a_i`, `b_r`, `b_i`  in  WIDTH each: operand components.
- `clear`  in  1: synchronous abort that discards any partial accumulation.
- `out_valid`  out  1: result strobe, high for one cycle.
- `out_r`, `out_i`  out  WIDTH each: rounded, saturated result.
- `out_sat`  out  1: high with `out_valid` if either component saturated.

## Operation
- No backpressure; a beat is accepted every cycle that `in_valid`=1. Bubbles (`in_valid`=0) are allowed anywhere, including inside a vector.
- Stage P (pre-add), registered at WIDTH+1 bits:
  - b_i' = `in_conj` ? -b_i : b_i
  - s0 = a_r + a_i
  - s1 = b_i' - b_r
  - s2 = b_r + b_i'
  - Registered copies of a_r, a_i and b_r travel alongside.
- Stage M, three signed multipliers with MULT_CYCLES registers and full 2*WIDTH+2-bit results:
  - k1 = b_r*s0
  - k2 = a_r*s1
  - k3 = a_i*s2
- Stage S (post-add), sign-extended to ACC_WIDTH: pr = k1 - k3, pi = k1 + k2.
- Stage A (accumulate):
  - A first-beat flag is set by reset, `clear`, and each accepted `in_last`.
  - On a valid beat with the flag set, acc <= p; otherwise acc <= acc + p.
  - The accumulator wraps modulo 2^ACC_WIDTH. Sizing is the user's responsibility; the default covers 256 full-scale terms.
- Stage R (round and saturate), applied per component only on beats carrying `last`:
  - t = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half toward +inf.
  - Clamp t to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set `out_sat` if clamping occurred.
- `valid`, `last` and `conj` shift alongside the data. Only `last` beats produce `out_valid`.
- A vector of a single beat (`in_valid`=`in_last`=1 with the flag set) outputs that beat's product alone.
- `clear`:
  - Kills every in-flight beat (valid bits cleared in P, M and S) and sets the first-beat flag.
  - A result already registered in R still emits.
  - `clear` together with a valid input beat: the beat is dropped.

## Timing
- Latency from an accepted `in_last` beat to `out_valid`: L = MULT_CYCLES + 4 cycles (P=1, M=MULT_CYCLES, S=1, A=1, R=1). Default L = 6.
- Throughput: one beat per cycle. Back-to-back vectors need no gap.
- Consecutive single-beat vectors give `out_valid` on consecutive cycles.
- `out_r`, `out_i` and `out_sat` hold their values between strobes.
- Reset values:
  - `out_valid`=0, `out_r`=0, `out_i`=0, `out_sat`=0.
  - All pipeline valid bits are 0, the accumulator is 0, and the first-beat flag is 1.
- Reset asserted mid-vector: the partial sum is lost. The first valid beat after deassertion starts a new vector.

## Test plan
- Basic product, defaults: a=(8192,8192), b=(8192,-8192), `in_conj`=0, single beat with `in_last`=1 -> 6 cycles later `out_r`=8192, `out_i`=0, `out_sat`=0.
- Conjugate mode: same operands with `in_conj`=1 -> `out_r`=0, `out_i`=8192.
- Accumulate with bubbles: four beats of a=(16384,0), b=(4096,0), with `in_valid`=0 between beats 2 and 3, `last` on beat 4 -> a single `out_valid`, `out_r`=16384, `out_i`=0. No strobe occurs on beats 1–3.
- Saturation: four beats of a=(24576,0), b=(24576,0) (1.5×1.5 each) -> `out_r`=32767, `out_sat`=1. Repeat with b=(-24576,0) -> `out_r`=-32768, `out_sat`=1.
- Rounding: a=(1,0), b=(8192,0) -> `out_r`=1. Then a=(-1,0), b=(8192,0) -> `out_r`=0.
- `clear` and reset:
  - Three beats of a vector, assert `clear` for 1 cycle, then a single `last` beat a=(8192,8192), b=(8192,-8192) -> output equals the basic case.
  - Async `reset` pulse mid-vector -> all outputs read 0 immediately, and no spurious `out_valid` appears.
